// File: rtl/enc_period_pkg.sv
// enc_period_pkg
// Shared types and constants for the encoder period snapshot scheduler.
//   state_t      - scan FSM states
//   PER_OVF_BIT  - overflow flag position inside a period word
//   PER_CNT_MSB  - MSB of the count field inside a period word
//   DEF_*        - default parameter values for enc_period_scan
package enc_period_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE_W,
        SAMPLE,
        COMPARE,
        WRITE,
        DONE
    } state_t;

    localparam int PER_OVF_BIT = 26;
    localparam int PER_CNT_MSB = 21;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CH_W      = 2;
    localparam int DEF_SETTLE    = 2;
    localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/enc_period_stable.sv
// enc_period_stable
// Compare-and-retry capture of the period word that crosses in from the fast
// clock domain. A pulse on start records the current word; on every following
// cycle the live word is compared with the recorded one. A match yields the
// recorded word. A mismatch re-records and spends one retry; once the retries
// are used up the live word is taken as-is and flagged unstable.
// Ports:
//   clk, reset  - system clock, asynchronous active-low reset
//   start       - begin a capture (one cycle)
//   period_in   - selected channel's period word
//   valid       - capture result available this cycle
//   value       - captured word (meaningful while valid)
//   unstable    - capture was forced after retries ran out (while valid)
module enc_period_stable
    import enc_period_pkg::*;
#(
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] period_in,
    output logic        valid,
    output logic [31:0] value,
    output logic        unstable
);

    logic        active;
    logic [31:0] prev;
    logic [2:0]  retry;
    logic        match;

    assign match    = (period_in == prev);
    assign valid    = active & (match | (retry == 3'd0));
    assign value    = match ? prev : period_in;
    assign unstable = ~match;

    // NOTE: state registers are updated with <= so every reader in this
    // clock sees the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            prev   <= '0;
            retry  <= '0;
        end else if (start) begin
            active <= 1'b1;
            prev   <= period_in;
            retry  <= 3'(MAX_RETRY);
        end else if (active) begin
            if (valid) begin
                active <= 1'b0;
            end else begin
                prev  <= period_in;
                retry <= retry - 3'd1;
            end
        end
    end

endmodule

// File: rtl/enc_period_scan.sv
// enc_period_scan
// Snapshot scheduler sharing one period readout path between NUM_CH encoder
// channels. A request walks every channel: select it, wait SETTLE cycles,
// capture a stable word, store it in the bank and update the per-channel
// overflow / unstable flags. Requests arriving mid-scan coalesce into one
// pending rescan.
// Optional feature (macro ENC_PERIOD_TSTAMP_EN): scan_tstamp reports the clk
// cycles between the start of the previous scan and the start of this one,
// saturating at 16'hFFFF; 0 for the first scan after reset.
// Ports:
//   clk, reset     - system clock, asynchronous active-low reset
//   sample_req     - scan request, rising level starts a scan
//   busy           - scan in progress (through the DONE cycle)
//   done           - one-cycle pulse at scan completion
//   chan_sel       - channel driving period_in
//   period_in      - selected channel's period word
//   rd_addr        - host read address
//   rd_data        - bank[rd_addr], one cycle latency
//   ovf_mask       - overflow flag of each channel's last capture
//   unstable_mask  - channel was force-captured on its last capture
//   scan_tstamp    - (ENC_PERIOD_TSTAMP_EN only) start-to-start interval
module enc_period_scan
    import enc_period_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CH_W      = DEF_CH_W,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_req,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   chan_sel,
    input  logic [31:0]       period_in,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [31:0]       rd_data,
`ifdef ENC_PERIOD_TSTAMP_EN
    output logic [15:0]       scan_tstamp,
`endif
    output logic [NUM_CH-1:0] ovf_mask,
    output logic [NUM_CH-1:0] unstable_mask
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t          state;
    logic            req_r;
    logic            pending;
    logic [CH_W-1:0] chan;
    logic [3:0]      settle_cnt;
    logic [31:0]     wr_value;
    logic            wr_unstable;
    logic [31:0]     bank [NUM_CH];

    logic            req_rise;
    logic            scan_go;
    logic            cmp_valid;
    logic [31:0]     cmp_value;
    logic            cmp_unstable;

    assign req_rise = sample_req & ~req_r;
    assign scan_go  = (state == IDLE) & (req_rise | pending);

    enc_period_stable #(
        .MAX_RETRY (MAX_RETRY)
    ) u_stable (
        .clk       (clk),
        .reset     (reset),
        .start     (state == SAMPLE),
        .period_in (period_in),
        .valid     (cmp_valid),
        .value     (cmp_value),
        .unstable  (cmp_unstable)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            req_r         <= 1'b0;
            pending       <= 1'b0;
            chan          <= '0;
            chan_sel      <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_value      <= '0;
            wr_unstable   <= 1'b0;
            rd_data       <= '0;
            ovf_mask      <= '0;
            unstable_mask <= '0;
            // NOTE: the bank is reset explicitly because the host may read it
            // before the first scan and must see zeros; this keeps it in flops.
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else begin
            req_r   <= sample_req;
            done    <= 1'b0;
            // Read-before-write: a same-cycle WRITE to rd_addr returns old data.
            rd_data <= (int'(rd_addr) < NUM_CH) ? bank[rd_addr] : '0;

            case (state)
                IDLE: begin
                    if (scan_go) begin
                        pending <= 1'b0;
                        chan    <= '0;
                        busy    <= 1'b1;
                        state   <= SELECT;
                    end
                end
                SELECT: begin
                    chan_sel   <= chan;
                    settle_cnt <= 4'(SETTLE);
                    state      <= SETTLE_W;
                end
                SETTLE_W: begin
                    // Stay SETTLE cycles in total: leave when the count hits 0.
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) state <= SAMPLE;
                end
                SAMPLE: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (cmp_valid) begin
                        wr_value    <= cmp_value;
                        wr_unstable <= cmp_unstable;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    bank[chan]          <= wr_value;
                    ovf_mask[chan]      <= wr_value[PER_OVF_BIT];
                    unstable_mask[chan] <= wr_unstable;
                    if (chan == LAST_CH) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        chan  <= chan + 1'b1;
                        state <= SELECT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Requests seen while scanning collapse into a single rescan.
            if (req_rise && state != IDLE) pending <= 1'b1;
        end
    end

`ifdef ENC_PERIOD_TSTAMP_EN
    logic [15:0] since_start;
    logic        started;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            since_start <= '0;
            started     <= 1'b0;
            scan_tstamp <= '0;
        end else if (scan_go) begin
            scan_tstamp <= started ? since_start : 16'd0;
            // The start edge itself counts as the first elapsed cycle.
            since_start <= 16'd1;
            started     <= 1'b1;
        end else if (since_start != 16'hFFFF) begin
            since_start <= since_start + 16'd1;
        end
    end
`endif

endmodule

// File: doc/enc_period_scan.md
# enc_period_scan

Snapshot scheduler for the encoder period-measurement units. It shares one 32-bit period readout path between NUM_CH channels. On a sample request it walks the channels in order, drives the channel select, and waits for the `clk_fast`-domain period word to settle in the `clk` domain. It then captures a stable value per channel into a register bank that the host read logic reads by address, and aggregates per-channel overflow flags.

## Interface
- NUM_CH, 4, number of encoder channels scanned (2..16)
- CH_W, 2, select/address width (= clog2(NUM_CH))
- SETTLE, 2, clk cycles waited after chan_sel changes before first sample (1..15)
- MAX_RETRY, 3, extra stability compares before forced capture (0..7)
- clk  in  1  system clock (sysclk); one clock domain
- reset  in  1  asynchronous, active-low reset
- sample_req  in  1  request a full scan (level sampled each cycle; rising level treated as request)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when scan completes
- chan_sel  out  CH_W  selects which channel's period drives period_in
- period_in  in  32  selected channel's period word (bit26 = overflow flag, bits21:0 = count)
- rd_addr  in  CH_W  host read channel
- rd_data  out  32  bank[rd_addr], registered
- ovf_mask  out  NUM_CH  bit n = overflow flag of channel n's last capture
- unstable_mask  out  NUM_CH  bit n = channel n was force-captured after retries exhausted

## Operation
- States: IDLE, SELECT, SETTLE_W, SAMPLE, COMPARE, WRITE, DONE.
- IDLE: on sample_req rising (sample_req & ~sample_req_r) or pending set, clear pending, set chan = 0, go SELECT.
- SELECT: drive chan_sel = chan, load settle counter = SETTLE, go SETTLE_W.
- SETTLE_W: decrement; at 0 go SAMPLE.
- SAMPLE: A <= period_in, retry counter = MAX_RETRY, go COMPARE.
- COMPARE: if period_in == A, go WRITE with value A. Else if retry counter is 0, go WRITE with period_in and flag unstable. Else A <= period_in, decrement, stay.
- WRITE: bank[chan] <= value, ovf_mask[chan] <= value[26], unstable_mask[chan] <= flag. If chan == NUM_CH-1, go DONE; else chan++ and go SELECT.
- DONE: done = 1 for one cycle, go IDLE.
- Request during busy: set the single pending bit. Further requests coalesce into it. The scan restarts from DONE→IDLE on the next cycle.
- Masks update per channel as captured, not atomically. The host reads after done.
- chan_sel holds its last value in IDLE.

## Timing
- Reset values: busy 0, done 0, chan_sel 0, rd_data 0, ovf_mask 0, unstable_mask 0, bank all 0, pending 0, state IDLE.
- Reset mid-scan: immediate return to IDLE with all of the above cleared; the partial scan is discarded.
- Per-channel latency, stable input: 1 (SELECT) + SETTLE + 1 (SAMPLE) + 1 (COMPARE) + 1 (WRITE) cycles.
- Full scan, stable input: NUM_CH·(SETTLE+4) cycles, plus 1 for DONE. Defaults give 4·6+1 = 25 cycles from request edge to done.
- Each unstable compare adds 1 cycle, up to MAX_RETRY.
- busy is 1 from the cycle after the request edge through the DONE cycle.
- rd_data = bank[rd_addr] one cycle after rd_addr.
- A WRITE and a read of the same address in the same cycle return the old value.
- chan wraps only through IDLE, never past NUM_CH-1.

## Configuration
- ENC_PERIOD_TSTAMP_EN defined:
  - adds output scan_tstamp [15:0], the number of clk cycles between the start of the previous scan and the start of this one;
  - latched at IDLE→SELECT;
  - saturates at 16'hFFFF;
  - reset value 0; the first scan after reset reports 0.
- Undefined: no port and no counter.

## Structure
- Package enc_period_pkg:
  - state enum;
  - PER_OVF_BIT = 26, PER_CNT_MSB = 21;
  - default parameter constants.
- Sub-module enc_period_stable:
  - holds the SAMPLE/COMPARE compare-and-retry logic (A register, retry counter);
  - inputs start, period_in; outputs valid, value, unstable.
- Top level keeps the FSM, bank and masks.

## Test plan
- Stable inputs 32'h0000_1234 + n per channel, single request: done at cycle 25; bank[n] = 1234+n; masks 0; rd_addr=2 gives 32'h0000_1236 one cycle later.
- Channel 1 period_in toggles every cycle between 5 and 6: forced capture after 3 retries; unstable_mask = 4'b0010; done at cycle 28.
- Channel 3 word has bit26 set (32'h0400_0000 | 22'h3FFFFF): ovf_mask = 4'b1000.
- Three requests during a busy scan: exactly one extra scan, two done pulses total.
- Reset low at cycle 10 of a scan: all outputs 0 immediately. A new request after release completes normally.
- With ENC_PERIOD_TSTAMP_EN, requests 100 cycles apart: second scan_tstamp = 100.
